// File: rtl/dti_uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling
// constants and the data-bit-count decode shared with the transmitter.
package dti_uart_pkg;

    localparam int CFG_DATA_WIDTH = 8;
    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] MID_TICK = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // 00=5, 01=6, 10=7, 11=8 data bits
    function automatic logic [3:0] data_bit_count(
        input logic [1:0] sel
    );
        return 4'd5 + {2'b00, sel};
    endfunction

    function automatic logic [7:0] data_mask(
        input logic [1:0] sel
    );
        return 8'hFF >> (2'd3 - sel);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input,
// with a selectable reset value so an idle-high line never looks like a start.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop capture
// with sticky status bits for the register block and rts_n flow control.
module uart_receiver
    import dti_uart_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken16,
    input  logic                  rx,
    input  logic [1:0]            cfg_data_bit_num,
    input  logic                  cfg_stop_bit_num,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_type,
    input  logic                  host_read_stt_rx_done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  stt_rx_done,
    output logic                  stt_parity_err,
    output logic                  stt_frame_err,
    output logic                  stt_overrun,
    output logic                  rts_n
);

    rx_state_t state;
    rx_state_t state_nxt;

    logic       rx_s;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic [7:0] shreg;
    logic       par_err;
    logic       frm_err;

    logic [7:0] mask;
    logic       tick_mid;
    logic       tick_bit;
    logic       last_bit;
    logic       last_stop;
    logic       exp_par;

    logic start_det;
    logic start_ok;
    logic data_smp;
    logic par_smp;
    logic stop_smp;
    logic frame_done;

    uart_rx_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (rx),
        .q      (rx_s)
    );

    assign mask     = data_mask(cfg_data_bit_num);
    assign tick_mid = clken16 && (tick_cnt == MID_TICK);
    assign tick_bit = clken16 && (tick_cnt == LAST_TICK);
    // >= keeps the FSM moving if the width shrinks mid-frame
    assign last_bit = ({1'b0, bit_cnt} >=
                       (data_bit_count(cfg_data_bit_num) - 4'd1));
    assign last_stop = stop_cnt || !cfg_stop_bit_num;
    assign exp_par   = (^(shreg & mask)) ^ cfg_parity_type;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (clken16 && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick_mid) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_bit && last_bit) begin
                    state_nxt = cfg_parity_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick_bit) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick_bit && last_stop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_det  = 1'b0;
        start_ok   = 1'b0;
        data_smp   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE:   start_det = clken16 && !rx_s;
            START:  start_ok  = tick_mid && !rx_s;
            DATA:   data_smp  = tick_bit;
            PARITY: par_smp   = tick_bit;
            STOP: begin
                stop_smp   = tick_bit;
                frame_done = tick_bit && last_stop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (start_det || start_ok) begin
            tick_cnt <= '0;
        end else if (clken16) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else if (start_det) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            if (data_smp) begin
                shreg[bit_cnt] <= rx_s;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (par_smp && (rx_s != exp_par)) begin
                par_err <= 1'b1;
            end
            if (stop_smp) begin
                stop_cnt <= 1'b1;
                if (!rx_s) begin
                    frm_err <= 1'b1;
                end
            end
        end
    end

    // A completing frame beats a simultaneous host clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data        <= '0;
            stt_rx_done    <= 1'b0;
            stt_parity_err <= 1'b0;
            stt_frame_err  <= 1'b0;
            stt_overrun    <= 1'b0;
        end else if (frame_done) begin
            rx_data        <= DATA_WIDTH'(shreg & mask);
            stt_rx_done    <= 1'b1;
            stt_parity_err <= par_err;
            stt_frame_err  <= frm_err || !rx_s;
            stt_overrun    <= stt_rx_done;
        end else if (host_read_stt_rx_done) begin
            stt_rx_done    <= 1'b0;
            stt_parity_err <= 1'b0;
            stt_frame_err  <= 1'b0;
            stt_overrun    <= 1'b0;
        end
    end

    assign rts_n = stt_rx_done;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model
// compared against the DUT outputs on every clock.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clken16 = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] cfg_data_bit_num = 2'd3;
    logic       cfg_stop_bit_num = 1'b0;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_type = 1'b0;
    logic       host_read = 1'b0;

    logic [7:0] rx_data;
    logic       stt_rx_done;
    logic       stt_parity_err;
    logic       stt_frame_err;
    logic       stt_overrun;
    logic       rts_n;

    logic [7:0] m_data = 8'h00;
    logic       m_done = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    int total = 0;
    int bad = 0;
    int div = 0;
    bit running = 1'b1;

    uart_receiver #(
        .DATA_WIDTH(8)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .clken16              (clken16),
        .rx                   (rx),
        .cfg_data_bit_num     (cfg_data_bit_num),
        .cfg_stop_bit_num     (cfg_stop_bit_num),
        .cfg_parity_en        (cfg_parity_en),
        .cfg_parity_type      (cfg_parity_type),
        .host_read_stt_rx_done(host_read),
        .rx_data              (rx_data),
        .stt_rx_done          (stt_rx_done),
        .stt_parity_err       (stt_parity_err),
        .stt_frame_err        (stt_frame_err),
        .stt_overrun          (stt_overrun),
        .rts_n                (rts_n)
    );

    always #5 clk = ~clk;

    // one enable every 4 clocks, changed away from the active edge
    always @(negedge clk) begin
        clken16 <= (div == 3);
        div     <= (div + 1) % 4;
    end

    task automatic wait_tick();
        do @(posedge clk); while (clken16 !== 1'b1);
    endtask

    task automatic send_bit(input logic b, input int n);
        #1 rx = b;
        repeat (n) wait_tick();
    endtask

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        m_done = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic host_rd();
        @(posedge clk);
        #1 host_read = 1'b1;
        @(posedge clk);
        model_clear();
        #1 host_read = 1'b0;
    endtask

    task automatic glitch(input int len);
        wait_tick();
        #1 rx = 1'b0;
        repeat (len) wait_tick();
        #1 rx = 1'b1;
        repeat (24) wait_tick();
    endtask

    task automatic frame(input logic [7:0] data,
                         input logic [1:0] dsel,
                         input logic s2,
                         input logic pen,
                         input logic ptype,
                         input logic bad_par,
                         input logic [1:0] bad_stop,
                         input logic hr);
        int nb;
        int ns;
        logic [7:0] d;
        logic pbit;
        logic ferr;
        logic b;
        cfg_data_bit_num = dsel;
        cfg_stop_bit_num = s2;
        cfg_parity_en    = pen;
        cfg_parity_type  = ptype;
        nb   = 5 + int'(dsel);
        d    = 8'(int'(data) % (1 << nb));
        pbit = (^d) ^ ptype ^ bad_par;
        ns   = s2 ? 2 : 1;
        ferr = 1'b0;
        wait_tick();
        send_bit(1'b0, 16);
        for (int i = 0; i < nb; i++) send_bit(d[i], 16);
        if (pen) send_bit(pbit, 16);
        for (int j = 0; j < ns; j++) begin
            b = !bad_stop[j];
            ferr = ferr | !b;
            if (j == ns - 1) begin
                #1 rx = b;
                repeat (8) wait_tick();
                if (hr) begin
                    repeat (3) @(posedge clk);
                    #1 host_read = 1'b1;
                end
                wait_tick();
                m_ovr  = m_done;
                m_done = 1'b1;
                m_data = d;
                m_perr = pen && bad_par;
                m_ferr = ferr;
                if (hr) #1 host_read = 1'b0;
                repeat (7) wait_tick();
            end else begin
                send_bit(b, 16);
            end
        end
        send_bit(1'b1, 16);
    endtask

    task automatic check_stat(input string name,
                              input logic [7:0] d,
                              input logic [3:0] st);
        check({name, "_data"}, 32'(rx_data), 32'(d));
        check({name, "_stat"},
              {28'd0, stt_rx_done, stt_parity_err,
               stt_frame_err, stt_overrun},
              {28'd0, st});
        check({name, "_rts"}, 32'(rts_n), 32'(st[3]));
    endtask

    initial begin
        logic [12:0] got;
        logic [12:0] exp;
        logic [7:0] rd;
        logic [1:0] rsel;
        logic [1:0] rstop;
        fork
            forever begin
                @(negedge clk);
                if (running) begin
                    got = {rx_data, stt_rx_done, stt_parity_err,
                           stt_frame_err, stt_overrun, rts_n};
                    exp = {m_data, m_done, m_perr,
                           m_ferr, m_ovr, m_done};
                    total++;
                    if (got !== exp) begin
                        bad++;
                        if (bad <= 20)
                            $display("FAIL cycle_cmp t=%0t got=%0h exp=%0h",
                                     $time, got, exp);
                    end
                end
            end
        join_none

        repeat (5) @(posedge clk);
        check_stat("reset", 8'h00, 4'b0000);
        #1 reset_n = 1'b1;
        repeat (8) wait_tick();

        frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check_stat("8n1_a5", 8'hA5, 4'b1000);
        host_rd();

        frame(8'h13, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check_stat("5e2_13", 8'h13, 4'b1000);
        host_rd();
        frame(8'h13, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        check_stat("5e2_perr", 8'h13, 4'b1100);
        host_rd();

        glitch(4);
        check_stat("glitch", 8'h13, 4'b0000);

        frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        check_stat("ferr_3c", 8'h3C, 4'b1010);
        host_rd();

        frame(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        frame(8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check_stat("ovr_22", 8'h22, 4'b1001);
        host_rd();
        check_stat("rd_clr", 8'h22, 4'b0000);

        frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        frame(8'h66, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        check_stat("rd_same", 8'h66, 4'b1001);

        // reset in the middle of a frame
        wait_tick();
        send_bit(1'b0, 16);
        send_bit(1'b1, 20);
        #1 reset_n = 1'b0;
        model_clear();
        m_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (32) wait_tick();
        check_stat("mid_rst", 8'h00, 4'b0000);

        for (int n = 0; n < 30; n++) begin
            rd    = 8'($urandom);
            rsel  = 2'($urandom_range(0, 3));
            rstop = ($urandom_range(0, 4) == 0) ?
                    2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1) host_rd();
            if ($urandom_range(0, 5) == 0)
                glitch($urandom_range(1, 6));
            frame(rd, rsel,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) == 0),
                  rstop,
                  1'($urandom_range(0, 6) == 0));
        end

        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage of the dti_uart: the counterpart of the UART transmit path on the far end of the `rx` line. It oversamples `rx` with a 16x clock-enable from the baud generator, validates the start bit, shifts in 5–8 data bits LSB-first, and checks optional parity and 1 or 2 stop bits. It then presents the byte to the register block with sticky status bits and drives `rts_n` flow control.

## Interface
- DATA_WIDTH, `CFG_DATA_WIDTH` (8): width of `rx_data`; the frame carries at most 8 data bits.
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- clken16  input  1  one-cycle enable pulse, 16 per bit period
- rx  input  1  serial input, asynchronous, idle high
- cfg_data_bit_num  input  2  data bits: 00=5, 01=6, 10=7, 11=8
- cfg_stop_bit_num  input  1  0=1 stop bit, 1=2 stop bits
- cfg_parity_en  input  1  parity bit present after the data bits
- cfg_parity_type  input  1  0=even, 1=odd
- host_read_stt_rx_done  input  1  one-cycle pulse: host read of the status register
- rx_data  output  DATA_WIDTH  last received byte, zero-extended above the configured data width
- stt_rx_done  output  1  sticky: a frame has completed
- stt_parity_err  output  1  sticky: parity mismatch in the last frame
- stt_frame_err  output  1  sticky: a stop bit was sampled low
- stt_overrun  output  1  sticky: a frame completed while `stt_rx_done` was still set
- rts_n  output  1  active-low ready-to-send, equal to `stt_rx_done`

## Operation
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. All sampling uses the synchronized value `rx_s`.
- A 4-bit tick counter counts `clken16` pulses. A bit counter and a shift register hold frame progress.
- **IDLE:** on a `clken16` tick with `rx_s`=0, go to START and clear the tick counter.
- **START:** on tick 7 (the bit midpoint), sample `rx_s`.
  - If `rx_s`=1, the start bit was a glitch: return to IDLE with no status change.
  - If `rx_s`=0, go to DATA and clear the tick counter.
- **DATA:** every 16th tick, sample `rx_s` into bit position `bit_cnt`, LSB first. After the last configured bit, go to PARITY if `cfg_parity_en`, otherwise go to STOP.
- **PARITY:** sample at 16 ticks.
  - Expected parity bit = XOR of the received data bits, XOR `cfg_parity_type`.
  - A mismatch latches an internal parity-error flag.
- **STOP:** sample at 16 ticks. Any stop sample of 0 latches an internal frame-error flag. With `cfg_stop_bit_num`=1, take a second sample 16 ticks later.
- **Frame completion** happens at the last stop sample, mid-bit. The FSM returns to IDLE immediately so it can resynchronize on the next start edge.
  - `rx_data` loads the shift register, with unused upper bits set to 0.
  - `stt_rx_done` sets. `stt_parity_err` and `stt_frame_err` load the internal flags.
  - If `stt_rx_done` was already 1, `stt_overrun` sets and `rx_data` is overwritten.
- **Host read:** `host_read_stt_rx_done` clears all four sticky bits. If it arrives in the same cycle as a frame completion, the set wins and the overrun bit evaluates the pre-clear value.
- **Configuration changes** mid-frame: undefined frame contents; the FSM must still return to IDLE within one frame time.

## Timing
- Reset values: `rx_data`=0, all stt_* = 0, `rts_n`=0. FSM resets to IDLE, counters to 0, synchronizer flops to 1.
- `rx` to `rx_s` latency: 2 clk.
- The start bit is sampled 8 ticks after the detected falling edge. Every later sample is 16 ticks apart.
- Sticky outputs update on the clk edge after the `clken16` tick of the final stop sample.
- `rts_n` follows `stt_rx_done` in the same cycle; it is combinational from the flop.
- Reset asserted mid-frame aborts the frame with no status set.

## Structure
- Shared package `dti_uart_pkg` holds:
  - the FSM enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE`=16 and `MID_TICK`=7;
  - a data-bit-count decode function shared with the transmitter.
- One sub-module: `uart_rx_sync`, a 2-flop synchronizer with reset value parameter `RST_VAL`=1.

## Test plan
- 8N1 frame carrying 0xA5 at 16x -> `rx_data`=0xA5, `stt_rx_done`=1, `rts_n`=1, no error bits set.
- 5-bit, even parity, 2 stop bits, data 0x13 -> `rx_data`=0x13 with bits [7:5]=0. Then a corrupted parity bit -> `stt_parity_err`=1.
- `rx` low pulse of 4 ticks while idle -> FSM returns to IDLE and all status bits stay 0.
- 8N1 frame 0x3C with the stop bit forced low -> `stt_frame_err`=1, `rx_data`=0x3C.
- Two frames 0x11 then 0x22 with no host read between them -> `stt_overrun`=1, `rx_data`=0x22. A host read pulse then clears all status bits.
- `host_read_stt_rx_done` in the same cycle as a frame completion -> `stt_rx_done` stays 1.
